// File: rtl/outr_serial_tx_if.sv
// CU-facing load bus of the OUTR stage: load strobe/data toward the stage,
// flag-out, busy and OUTR contents back to the control unit.
interface outr_serial_tx_if;
    logic       out_ld;
    logic [7:0] out_data;
    logic       fgo;
    logic       busy;
    logic [7:0] outr;

    modport master (
        output out_ld,
        output out_data,
        input  fgo,
        input  busy,
        input  outr
    );

    modport slave (
        input  out_ld,
        input  out_data,
        output fgo,
        output busy,
        output outr
    );
endinterface

// File: rtl/outr_serial_tx.sv
// OUTR register plus 8N1 serial transmitter with FGO flag and IEN-gated irq.
// Define OUTR_PARITY_EN to insert an even-parity bit between data and stop.
module outr_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 12
) (
    input  logic            clk,
    input  logic            reset,
    outr_serial_tx_if.slave bus,
    input  logic            ien_set,
    input  logic            ien_clr,
    output logic            tx,
    output logic            irq
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OUTR_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       outr_q, outr_d;
    logic             fgo_q, fgo_d;
    logic             ien_q, ien_d;
    logic             irq_q, irq_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        outr_d  = outr_q;
        fgo_d   = fgo_q;
        bit_end = (cnt_q == LAST_CNT);
        cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.out_ld && fgo_q) begin
                    outr_d  = bus.out_data;
                    fgo_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef OUTR_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef OUTR_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    fgo_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // clear beats set when both strobes arrive together
        ien_d = ien_q;
        if (ien_clr)      ien_d = 1'b0;
        else if (ien_set) ien_d = 1'b1;
        irq_d = ien_d & fgo_d;

        // tx is registered from next-state values so the line is glitch-free
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = outr_d[idx_d];
`ifdef OUTR_PARITY_EN
            PARITY:  tx_d = ^outr_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            outr_q  <= '0;
            fgo_q   <= 1'b1;
            ien_q   <= 1'b0;
            irq_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            outr_q  <= outr_d;
            fgo_q   <= fgo_d;
            ien_q   <= ien_d;
            irq_q   <= irq_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign irq      = irq_q;
    assign bus.fgo  = fgo_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.outr = outr_q;

endmodule

// File: tb/tb_outr_serial_tx.sv
// Scoreboard bench for outr_serial_tx: frame-timing reference model, UART
// receiver decoding tx, and directed plus randomized load/IEN stimulus.
module tb_outr_serial_tx;

    localparam int unsigned C = 4;
`ifdef OUTR_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ien_set = 1'b0;
    logic ien_clr = 1'b0;
    logic tx, irq;

    outr_serial_tx_if bus ();

    outr_serial_tx #(.CLKS_PER_BIT(C), .CNT_W(12)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .ien_set (ien_set),
        .ien_clr (ien_clr),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is simply "FRAME cycles remaining after accept".
    int unsigned remain = 0;
    logic [7:0]  outr_m = 8'h00;
    logic        ien_m  = 1'b0;
    int          n_acc  = 0;
    bit          started = 0;
    logic [7:0]  exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            started <= 1;
            remain  <= 0;
            outr_m  <= 8'h00;
            ien_m   <= 1'b0;
        end else begin
            ien_m <= ien_clr ? 1'b0 : (ien_set ? 1'b1 : ien_m);
            if (bus.out_ld && remain == 0) begin
                remain <= FRAME;
                outr_m <= bus.out_data;
                n_acc  <= n_acc + 1;
                exp_q.push_back(bus.out_data);
            end else if (remain != 0) begin
                remain <= remain - 1;
            end
        end
    end

    function automatic logic exp_tx(input int unsigned rem, input logic [7:0] d);
        int unsigned b;
        if (rem == 0) return 1'b1;
        b = (FRAME - rem) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef OUTR_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Monitor: per-cycle output checks plus a mid-bit sampling UART receiver.
    bit          rx_act = 0;
    int unsigned rx_cnt = 0;
    logic [NB-1:0] rx_bits;
    int          n_rx = 0;

    always @(negedge clk) begin
        logic [7:0] want;
        logic [7:0] got;
        int unsigned k;
        if (started) begin
            check("tx",   32'(tx),       32'(exp_tx(remain, outr_m)));
            check("fgo",  32'(bus.fgo),  32'(remain == 0));
            check("busy", 32'(bus.busy), 32'(remain != 0));
            check("irq",  32'(irq),      32'(ien_m & (remain == 0)));
            check("outr", 32'(bus.outr), 32'(outr_m));
        end
        if (reset) begin
            rx_act = 0;
            rx_cnt = 0;
            exp_q.delete();
        end else if (started) begin
            if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && (rx_cnt % C) == C / 2) begin
                k = rx_cnt / C;
                rx_bits[k] = tx;
                if (k == NB - 1) begin
                    rx_act = 0;
                    n_rx++;
                    got = rx_bits[8:1];
                    check("rx_start", 32'(rx_bits[0]), 32'(0));
                    check("rx_stop",  32'(rx_bits[NB-1]), 32'(1));
                    check("rx_pending", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check("rx_byte", 32'(got), 32'(want));
`ifdef OUTR_PARITY_EN
                        check("rx_parity", 32'(rx_bits[9]), 32'(^want));
`endif
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        bus.out_ld   = 1'b1;
        bus.out_data = d;
        tick();
        bus.out_ld   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < int'(FRAME) * 2 + 4; i++) begin
            if (remain == 0) break;
            tick();
        end
        check("wait_idle_fgo", 32'(bus.fgo), 32'(1));
    endtask

    initial begin
        int base;
        bus.out_ld   = 1'b0;
        bus.out_data = 8'h00;

        // reset for two cycles
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_tx",   32'(tx),       32'(1));
        check("rst_fgo",  32'(bus.fgo),  32'(1));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_irq",  32'(irq),      32'(0));
        check("rst_outr", 32'(bus.outr), 32'(8'h00));

        // basic frame
        load(8'hA5);
        wait_idle();
        check("a5_outr", 32'(bus.outr), 32'(8'hA5));

        // load while busy is ignored
        load(8'h3C);
        repeat (8) tick();
        load(8'hFF);
        check("ign_outr", 32'(bus.outr), 32'(8'h3C));
        wait_idle();
        check("3c_outr", 32'(bus.outr), 32'(8'h3C));

        // irq gated by IEN
        ien_set = 1'b1;
        tick();
        ien_set = 1'b0;
        load(8'h01);
        check("irq_busy", 32'(irq), 32'(0));
        wait_idle();
        check("irq_done", 32'(irq), 32'(1));
        ien_set = 1'b1;
        ien_clr = 1'b1;
        tick();
        ien_set = 1'b0;
        ien_clr = 1'b0;
        check("irq_clr_wins", 32'(irq), 32'(0));

        // reset mid-frame, then a clean frame
        load(8'h55);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_tx",   32'(tx),       32'(1));
        check("abort_fgo",  32'(bus.fgo),  32'(1));
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_outr", 32'(bus.outr), 32'(8'h00));
        load(8'h0F);
        wait_idle();
        check("0f_outr", 32'(bus.outr), 32'(8'h0F));

        // back-to-back: second load held until the first fgo=1 cycle
        base = n_acc;
        load(8'h7E);
        bus.out_ld   = 1'b1;
        bus.out_data = 8'h80;
        for (int i = 0; i < int'(FRAME) + 4; i++) begin
            if (n_acc >= base + 2) break;
            tick();
        end
        bus.out_ld = 1'b0;
        check("b2b_accepts", 32'(n_acc - base), 32'(2));
        wait_idle();
        check("b2b_outr", 32'(bus.outr), 32'(8'h80));

        // randomized loads and IEN traffic
        for (int i = 0; i < 1500; i++) begin
            bus.out_ld   = ($urandom_range(0, 5) == 0);
            bus.out_data = 8'($urandom);
            ien_set      = ($urandom_range(0, 9) == 0);
            ien_clr      = ($urandom_range(0, 11) == 0);
            tick();
        end
        bus.out_ld = 1'b0;
        ien_set    = 1'b0;
        ien_clr    = 1'b0;
        wait_idle();
        repeat (2) tick();
        check("drain_queue", 32'(exp_q.size()), 32'(0));
        check("rx_frames_seen", 32'(n_rx > 8), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
